// File: rtl/puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF blocks.
package puf_pkg;

  localparam int CHAL_W_DEF = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    EVAL   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Bits needed to hold the values 0..n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/puf_sync.sv
// Multi-flop synchronizer for asynchronous single-bit PUF outputs.
module puf_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift chain; only the last stage is safe to use in clocked logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/puf_challenge_ctrl.sv
// PUF initiator: walks challenges, repeats each evaluation, majority-votes
// the synchronized result and flags bits whose votes disagreed.
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | enable low, oscillators and counters quiesce
// EVAL   | enable high, race window running
// SAMPLE | enable still high while the result crosses the synchronizer
// DONE   | one-cycle completion pulse
module puf_challenge_ctrl
  import puf_pkg::*;
#(
  parameter int CHAL_W        = CHAL_W_DEF,
  parameter int RESP_BITS     = 8,
  parameter int VOTES         = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int EVAL_CYCLES   = 1024,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAL_W-1:0]    challenge_base,
  output logic                 puf_enable,
  output logic [CHAL_W-1:0]    puf_challenge,
  input  logic                 puf_response,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic [RESP_BITS-1:0] unstable_mask
);

  localparam int TMR_MAX = (EVAL_CYCLES > SETTLE_CYCLES)
                           ? ((EVAL_CYCLES > SYNC_STAGES) ? EVAL_CYCLES : SYNC_STAGES)
                           : ((SETTLE_CYCLES > SYNC_STAGES) ? SETTLE_CYCLES : SYNC_STAGES);
  localparam int TW = cnt_w(TMR_MAX);
  localparam int VW = cnt_w(VOTES);
  localparam int BW = cnt_w(RESP_BITS - 1);

  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] EVAL_LD   = TW'(EVAL_CYCLES - 1);
  localparam logic [TW-1:0] SAMPLE_LD = TW'(SYNC_STAGES - 1);
  localparam logic [VW-1:0] V_HALF    = VW'(VOTES / 2);
  localparam logic [VW-1:0] V_ALL     = VW'(VOTES);
  localparam logic [VW-1:0] V_LAST    = VW'(VOTES - 1);
  localparam logic [BW-1:0] B_LAST    = BW'(RESP_BITS - 1);

  state_t                 state, state_nx;
  logic [TW-1:0]          tmr, tmr_ld;
  logic                   tc;
  logic                   sync_bit;
  logic [CHAL_W-1:0]      chal;
  logic [BW-1:0]          bit_idx;
  logic [VW-1:0]          vote_idx, ones, ones_nx;
  logic                   last_vote, last_bit, accept, sample_end;
  logic [RESP_BITS-1:0]   resp_r, mask_r;

  puf_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (puf_response),
    .q   (sync_bit)
  );

  assign tc         = (tmr == '0);
  assign last_vote  = (vote_idx == V_LAST);
  assign last_bit   = (bit_idx == B_LAST);
  assign accept     = (state == IDLE) && start;
  assign sample_end = (state == SAMPLE) && tc && !abort;
  assign ones_nx    = ones + VW'(sync_bit);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and timer reload value; abort overrides every transition.
  always_comb begin
    state_nx = state;
    tmr_ld   = '0;
    case (state)
      IDLE:    if (start) state_nx = SETTLE;
      SETTLE:  if (tc) state_nx = EVAL;
      EVAL:    if (tc) state_nx = SAMPLE;
      SAMPLE:  if (tc) state_nx = (last_vote && last_bit) ? DONE : SETTLE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort && state != IDLE) state_nx = IDLE;
    case (state_nx)
      SETTLE:  tmr_ld = SETTLE_LD;
      EVAL:    tmr_ld = EVAL_LD;
      SAMPLE:  tmr_ld = SAMPLE_LD;
      default: tmr_ld = '0;
    endcase
  end

  // Phase timer: down-counter reloaded on every state change, terminal count at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tmr <= '0;
    else if (state_nx != state) tmr <= tmr_ld;
    else if (!tc)               tmr <= tmr - TW'(1);
  end

  // Challenge/vote bookkeeping and progressive fill of the response words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chal     <= '0;
      bit_idx  <= '0;
      vote_idx <= '0;
      ones     <= '0;
      resp_r   <= '0;
      mask_r   <= '0;
    end else if (accept) begin
      chal     <= challenge_base;
      bit_idx  <= '0;
      vote_idx <= '0;
      ones     <= '0;
      resp_r   <= '0;
      mask_r   <= '0;
    end else if (sample_end) begin
      if (!last_vote) begin
        ones     <= ones_nx;
        vote_idx <= vote_idx + VW'(1);
      end else begin
        for (int i = 0; i < RESP_BITS; i++) begin
          if (bit_idx == BW'(i)) begin
            resp_r[i] <= (ones_nx > V_HALF);
            mask_r[i] <= (ones_nx != '0) && (ones_nx != V_ALL);
          end
        end
        ones     <= '0;
        vote_idx <= '0;
        if (!last_bit) begin
          bit_idx <= bit_idx + BW'(1);
          chal    <= chal + CHAL_W'(1);
        end
      end
    end
  end

  assign puf_enable    = (state == EVAL) || (state == SAMPLE);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign puf_challenge = chal;
  assign response      = resp_r;
  assign unstable_mask = mask_r;

endmodule

// File: doc/puf_challenge_ctrl.md
Name: puf_challenge_ctrl

Overview:
Initiator side of the ring-oscillator PUF. Drives challenge and enable into the PUF generator and samples its raw comparison bit through a synchronizer. Repeats each evaluation VOTES times and majority-votes the results into a RESP_BITS-wide response word. Flags unstable bits for the key-derivation / helper-data logic downstream, and reports completion with a start/busy/done handshake.

Parameters:
CHAL_W, 2, challenge width driven to the PUF generator
RESP_BITS, 8, response bits collected per run (1..32)
VOTES, 5, evaluations per bit; odd, 1..15
SETTLE_CYCLES, 4, cycles with enable low before each evaluation (oscillator/counter quiesce)
EVAL_CYCLES, 1024, cycles with enable high per evaluation (race window)
SYNC_STAGES, 2, synchronizer depth on puf_response

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  run request; honoured only in IDLE
abort  in  1  synchronous cancel of a run in progress
challenge_base  in  CHAL_W  first challenge of the run, captured on accepted start
puf_enable  out  1  enable to PUF generator
puf_challenge  out  CHAL_W  challenge to PUF generator
puf_response  in  1  raw, asynchronous PUF output bit
busy  out  1  high from cycle after accepted start until return to IDLE
done  out  1  one-cycle pulse; response/unstable_mask valid
response  out  RESP_BITS  majority-voted response; bit i from challenge i
unstable_mask  out  RESP_BITS  bit i = 1 if votes for bit i were not unanimous

Behaviour:
- Reset (async, any state): state=IDLE; puf_enable=0; puf_challenge=0; busy=0; done=0; response=0; unstable_mask=0; all counters, vote accumulator and synchronizer flops = 0.
- FSM states: IDLE, SETTLE, EVAL, SAMPLE, DONE.
- IDLE: start=1 at edge k -> capture base=challenge_base; bit_idx=0; vote_idx=0; ones=0; enter SETTLE at k+1. start while not IDLE is ignored.
- puf_challenge = (base + bit_idx) mod 2^CHAL_W. Wraps naturally; registered, stable for the whole bit.
- SETTLE: puf_enable=0 for exactly SETTLE_CYCLES cycles -> EVAL.
- EVAL: puf_enable=1 for exactly EVAL_CYCLES cycles -> SAMPLE.
- SAMPLE: puf_enable stays 1 for SYNC_STAGES cycles. On the last cycle, ones += synced bit.
  - If vote_idx < VOTES-1: vote_idx++ and go to SETTLE.
  - Else resolve: response[bit_idx] = (ones > VOTES/2); unstable_mask[bit_idx] = (ones != 0 && ones != VOTES). Then ones=0, vote_idx=0.
  - If bit_idx = RESP_BITS-1 go to DONE, else bit_idx++ and go to SETTLE.
- DONE: one cycle, done=1, puf_enable=0, busy=1 -> IDLE.
- Latency: L = RESP_BITS*VOTES*(SETTLE_CYCLES+EVAL_CYCLES+SYNC_STAGES). done is high in cycle k+1+L.
- response/unstable_mask hold their values from DONE until the next accepted start. On start they are cleared to 0 together with the counters, so bits fill in progressively during the run.
- abort=1 in any non-IDLE state: next state IDLE, puf_enable=0, busy=0, no done pulse; response/unstable_mask keep partial contents.
  - abort has priority over every transition, including DONE.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Counter widths: clog2 of each cycle parameter (+1). ones/vote_idx are clog2(VOTES+1) wide, so no overflow.
- puf_response is used only via the synchronizer; the raw input never reaches FSM logic.
- Reset asserted mid-run: immediate IDLE with all outputs at reset values. After deassertion the block waits for a new start.

Decomposition:
- Package puf_pkg: state enum (IDLE, SETTLE, EVAL, SAMPLE, DONE), CHAL_W default constant, and a clog2-based width helper for the counters.
- Sub-module puf_sync: SYNC_STAGES-deep flop synchronizer with async active-high reset to 0. It is reused by other PUF-side blocks.

Test Plan:
- Test parameters for all scenarios: SETTLE=2, EVAL=8, SYNC=2, VOTES=3, RESP_BITS=4.
- Basic run: puf_response tied 1, start with challenge_base=0. Expect done exactly 1+4*3*12=145 cycles after start, response=4'hF, unstable_mask=0. puf_challenge walks 0,1,2,3, each held for 36 cycles.
- Wrap and model response: challenge_base=2'b11, and a model PUF returns 1 only for challenge 1. Expect challenge sequence 3,0,1,2, response=4'b0100, unstable_mask=0.
- Majority voting: bit 0 returns votes 1,0,1 and bit 2 returns votes 0,0,1; all other bits unanimous 0. Expect response=4'b0001, unstable_mask=4'b0101.
- Abort: assert abort during EVAL of bit 2. Expect IDLE next cycle, puf_enable=0, busy=0, no done pulse, bits 0–1 retained. A new start then completes normally.
- Handshake and reset: start pulsed while busy is ignored, with done still at 145 cycles. Then async rst mid-SETTLE: outputs 0 immediately without a clock edge. After release, start yields a full run.
